// File: rtl/h264_wr_burst_sched.sv
// rtl/h264_wr_burst_sched.sv - DDR write-burst sequencer for the H.264 I-frame encoder output ring
module h264_wr_burst_sched #(
    parameter int BURST_LEN     = 16,
    parameter int NUM_BUF       = 4,
    parameter int BUF_SIZE_LOG2 = 22,
    parameter int FIFO_AW       = 10
) (
    input  logic               sys_clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic [9:0]         frame_ddr_addr_i,
    input  logic [FIFO_AW:0]   fifo_level_i,
    input  logic               frame_end_i,
    output logic               write_req_o,
    output logic [31:0]        write_start_addr_o,
    output logic [7:0]         write_length_o,
    input  logic               write_ackn_i,
    input  logic               write_done_i,
    input  logic               clr_intr_i,
    output logic               frm_interrupt_o,
    output logic [1:0]         frame_index_o,
    output logic [31:0]        frame_bytes_o,
    output logic               overrun_o,
    output logic               wrap_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_REQ,
        S_WAIT_DONE,
        S_REPORT
    } state_t;

    localparam logic [FIFO_AW:0] BURST_LVL   = (FIFO_AW + 1)'(BURST_LEN);
    localparam logic [8:0]       BURST_BEATS = 9'(BURST_LEN);
    localparam logic [1:0]       BUF_MASK    = 2'(NUM_BUF - 1);

    state_t                   state_q, state_d;
    logic [1:0]               buf_idx_q, buf_idx_d;
    logic [BUF_SIZE_LOG2-1:0] ofs_q, ofs_d;
    logic [31:0]              bytes_q, bytes_d;
    logic                     eof_seen_q, eof_seen_d;
    logic [8:0]               len_q, len_d;
    logic                     req_q, req_d;
    logic [31:0]              addr_q, addr_d;
    logic [7:0]               length_q, length_d;
    logic                     intr_q, intr_d;
    logic [1:0]               index_q, index_d;
    logic [31:0]              fbytes_q, fbytes_d;
    logic                     overrun_q, overrun_d;
    logic                     wrap_q, wrap_d;

    logic                     eof_now;
    logic [31:0]              burst_bytes;
    logic [BUF_SIZE_LOG2:0]   ofs_sum;
    logic [31:0]              burst_addr;
    logic [8:0]               new_len;
    logic                     start_burst;

    // frame_end_i counts immediately so an empty flush reports two cycles after the pulse
    assign eof_now     = eof_seen_q | frame_end_i;
    assign burst_bytes = {20'd0, len_q, 3'd0};
    assign ofs_sum     = {1'b0, ofs_q} + (BUF_SIZE_LOG2 + 1)'({len_q, 3'd0});
    assign burst_addr  = {frame_ddr_addr_i, 22'h0} + (32'(buf_idx_q) << BUF_SIZE_LOG2) + 32'(ofs_q);

    always_comb begin
        state_d     = state_q;
        buf_idx_d   = buf_idx_q;
        ofs_d       = ofs_q;
        bytes_d     = bytes_q;
        eof_seen_d  = eof_seen_q;
        len_d       = len_q;
        req_d       = req_q;
        addr_d      = addr_q;
        length_d    = length_q;
        intr_d      = intr_q;
        index_d     = index_q;
        fbytes_d    = fbytes_q;
        overrun_d   = overrun_q;
        wrap_d      = wrap_q;
        new_len     = BURST_BEATS;
        start_burst = 1'b0;

        if (state_q != S_IDLE && frame_end_i) begin
            eof_seen_d = 1'b1;
        end
        if (clr_intr_i) begin
            intr_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d = S_WAIT_DATA;
                    ofs_d   = '0;
                    bytes_d = '0;
                end
            end
            S_WAIT_DATA: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (fifo_level_i >= BURST_LVL) begin
                    new_len     = BURST_BEATS;
                    start_burst = 1'b1;
                end else if (eof_now && fifo_level_i != '0) begin
                    new_len     = fifo_level_i[8:0];
                    start_burst = 1'b1;
                end else if (eof_now) begin
                    state_d = S_REPORT;
                end
            end
            S_REQ: begin
                if (write_ackn_i) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (write_done_i) begin
                    ofs_d   = ofs_sum[BUF_SIZE_LOG2-1:0];
                    bytes_d = bytes_q + burst_bytes;
                    if (ofs_sum[BUF_SIZE_LOG2]) begin
                        wrap_d = 1'b1;
                    end
                    state_d = S_WAIT_DATA;
                end
            end
            S_REPORT: begin
                fbytes_d   = bytes_q;
                index_d    = buf_idx_q;
                intr_d     = 1'b1;
                overrun_d  = overrun_q | intr_q;
                buf_idx_d  = (buf_idx_q + 2'd1) & BUF_MASK;
                ofs_d      = '0;
                bytes_d    = '0;
                eof_seen_d = 1'b0;
                state_d    = enable_i ? S_WAIT_DATA : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // address and length are captured once and held until the arbiter accepts
        if (start_burst) begin
            state_d  = S_REQ;
            len_d    = new_len;
            req_d    = 1'b1;
            addr_d   = burst_addr;
            length_d = 8'(new_len - 9'd1);
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            buf_idx_q  <= '0;
            ofs_q      <= '0;
            bytes_q    <= '0;
            eof_seen_q <= 1'b0;
            len_q      <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            length_q   <= '0;
            intr_q     <= 1'b0;
            index_q    <= '0;
            fbytes_q   <= '0;
            overrun_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_idx_q  <= buf_idx_d;
            ofs_q      <= ofs_d;
            bytes_q    <= bytes_d;
            eof_seen_q <= eof_seen_d;
            len_q      <= len_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            length_q   <= length_d;
            intr_q     <= intr_d;
            index_q    <= index_d;
            fbytes_q   <= fbytes_d;
            overrun_q  <= overrun_d;
            wrap_q     <= wrap_d;
        end
    end

    assign write_req_o        = req_q;
    assign write_start_addr_o = addr_q;
    assign write_length_o     = length_q;
    assign frm_interrupt_o    = intr_q;
    assign frame_index_o      = index_q;
    assign frame_bytes_o      = fbytes_q;
    assign overrun_o          = overrun_q;
    assign wrap_o             = wrap_q;

endmodule

// File: tb/tb_h264_wr_burst_sched.sv
// tb/tb_h264_wr_burst_sched.sv - randomized frame-level bench for h264_wr_burst_sched
module tb_h264_wr_burst_sched;

    logic        clk = 1'b0;
    logic        reset, enable, frame_end, ackn, done, clr;
    logic [9:0]  ddr_addr;
    logic [10:0] fifo_level;
    logic        req1, intr1, ovr1, wrap1, req2, intr2, ovr2, wrap2;
    logic [31:0] addr1, bytes1, addr2, bytes2;
    logic [7:0]  len1, len2;
    logic [1:0]  idx1, idx2;

    always #5 clk = ~clk;

    h264_wr_burst_sched u_dut (
        .sys_clk_i(clk), .reset_i(reset), .enable_i(enable), .frame_ddr_addr_i(ddr_addr),
        .fifo_level_i(fifo_level), .frame_end_i(frame_end), .write_req_o(req1),
        .write_start_addr_o(addr1), .write_length_o(len1), .write_ackn_i(ackn),
        .write_done_i(done), .clr_intr_i(clr), .frm_interrupt_o(intr1), .frame_index_o(idx1),
        .frame_bytes_o(bytes1), .overrun_o(ovr1), .wrap_o(wrap1)
    );

    h264_wr_burst_sched #(.BUF_SIZE_LOG2(8)) u_small (
        .sys_clk_i(clk), .reset_i(reset), .enable_i(enable), .frame_ddr_addr_i(ddr_addr),
        .fifo_level_i(fifo_level), .frame_end_i(frame_end), .write_req_o(req2),
        .write_start_addr_o(addr2), .write_length_o(len2), .write_ackn_i(ackn),
        .write_done_i(done), .clr_intr_i(clr), .frm_interrupt_o(intr2), .frame_index_o(idx2),
        .frame_bytes_o(bytes2), .overrun_o(ovr2), .wrap_o(wrap2)
    );

    localparam logic [31:0] BASE = 32'h2800_0000;

    int n_err = 0;
    int n_chk = 0;
    int level = 0;
    int m_buf = 0;
    bit m_intr = 0;
    bit m_ovr = 0;
    bit m_wrap2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int b, input int ofs, input int lg);
        return BASE + (32'(b) << lg) + 32'(ofs % (1 << lg));
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_req"}, 32'(req1), 0);
        chk({tag, "_addr"}, addr1, 0);
        chk({tag, "_len"}, 32'(len1), 0);
        chk({tag, "_intr"}, 32'(intr1), 0);
        chk({tag, "_idx"}, 32'(idx1), 0);
        chk({tag, "_bytes"}, bytes1, 0);
        chk({tag, "_ovr"}, 32'(ovr1), 0);
        chk({tag, "_wrap"}, 32'(wrap1 | wrap2), 0);
    endtask

    task automatic idle_inputs();
        frame_end = 1'b0;
        ackn      = 1'b0;
        done      = 1'b0;
        clr       = 1'b0;
    endtask

    // One frame of n words: words arrive in random chunks, the bench acts as arbiter.
    task automatic run_frame(input int n, input int ack_fix);
        int lens[$];
        int rem = n;
        int ofs = 0;
        int phase = 0;
        int cnt = 0;
        int cur_len = 0;
        int cyc = 0;
        int k;
        bit ended = 0;
        for (int r = n; r > 0; r -= 16) lens.push_back(r >= 16 ? 16 : r);
        forever begin
            @(negedge clk);
            idle_inputs();
            cyc++;
            if (cyc > 4000) begin
                chk("frame_timeout", 1, 0);
                break;
            end
            if (phase == 0 && req1) begin
                if (lens.size() == 0) chk("spurious_req", 32'(req1), 0);
                else begin
                    cur_len = lens[0];
                    cnt = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
                    phase = 1;
                end
            end
            if (phase == 1) begin
                chk("req_hold", 32'(req1), 1);
                chk("addr", addr1, exp_addr(m_buf, ofs, 22));
                chk("len", 32'(len1), 32'(cur_len - 1));
                chk("addr_small", addr2, exp_addr(m_buf, ofs, 8));
                if (cnt == 0) begin
                    ackn = 1'b1;
                    phase = 2;
                    cnt = int'($urandom_range(0, 3));
                end else cnt--;
            end else if (phase == 2) begin
                chk("req_drop", 32'(req1), 0);
                if (cnt == 0) begin
                    done = 1'b1;
                    level -= cur_len;
                    ofs += cur_len * 8;
                    void'(lens.pop_front());
                    phase = 0;
                end else cnt--;
            end
            if (rem > 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    k = int'($urandom_range(1, 12));
                    if (k > rem) k = rem;
                    level += k;
                    rem -= k;
                end
            end else if (!ended) begin
                frame_end = 1'b1;
                ended = 1;
            end
            fifo_level = 11'(level);
            if (ended && lens.size() == 0 && phase == 0) break;
        end
        repeat (4) begin
            @(negedge clk);
            idle_inputs();
            chk("req_after_frame", 32'(req1), 0);
        end
        m_ovr   = m_ovr | m_intr;
        m_wrap2 = m_wrap2 | (n * 8 > 256);
        chk("frm_intr", 32'(intr1), 1);
        chk("frm_bytes", bytes1, 32'(n * 8));
        chk("frm_index", 32'(idx1), 32'(m_buf));
        chk("frm_overrun", 32'(ovr1), 32'(m_ovr));
        chk("frm_wrap", 32'(wrap1), 0);
        chk("frm_wrap_small", 32'(wrap2), 32'(m_wrap2));
        m_intr = 1;
        m_buf  = (m_buf + 1) % 4;
    endtask

    task automatic clear_intr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_intr", 32'(intr1), 0);
        m_intr = 0;
    endtask

    task automatic empty_frame(input bit coinc);
        @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        clr = coinc;
        chk("empty_lat1", 32'(intr1), 32'(m_intr));
        @(negedge clk);
        clr = 1'b0;
        m_ovr = m_ovr | m_intr;
        chk("empty_intr", 32'(intr1), 1);
        chk("empty_bytes", bytes1, 0);
        chk("empty_index", 32'(idx1), 32'(m_buf));
        chk("empty_overrun", 32'(ovr1), 32'(m_ovr));
        m_intr = 1;
        m_buf  = (m_buf + 1) % 4;
    endtask

    task automatic wait_req(input string tag);
        int i = 0;
        while (!req1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(req1), 1);
    endtask

    task automatic disable_test();
        level = 20;
        fifo_level = 11'(level);
        wait_req("dis_req");
        ackn = 1'b1;
        @(negedge clk);
        ackn = 1'b0;
        enable = 1'b0;
        chk("dis_req_drop", 32'(req1), 0);
        @(negedge clk);
        done = 1'b1;
        level -= 16;
        fifo_level = 11'(level);
        @(negedge clk);
        done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("dis_no_req", 32'(req1), 0);
            chk("dis_no_intr", 32'(intr1), 32'(m_intr));
        end
        level = 0;
        fifo_level = 0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_test();
        level = 20;
        fifo_level = 11'(level);
        wait_req("rst_req");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        reset = 1'b0;
        level = 0;
        fifo_level = 0;
        m_buf = 0;
        m_intr = 0;
        m_ovr = 0;
        m_wrap2 = 0;
        repeat (2) @(negedge clk);
    endtask

    function automatic int rand_words();
        int n = int'($urandom_range(1, 120));
        if (n == 32) n = 33;
        return n;
    endfunction

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        ddr_addr = 10'h0A0;
        fifo_level = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(40, 0);
        clear_intr();
        run_frame(20, 10);
        clear_intr();
        for (int f = 0; f < 2; f++) begin
            run_frame(rand_words(), -1);
            clear_intr();
        end
        run_frame(rand_words(), -1);
        empty_frame(1'b1);
        clear_intr();
        empty_frame(1'b0);
        clear_intr();
        disable_test();
        run_frame(rand_words(), -1);
        clear_intr();
        reset_test();
        run_frame(20, -1);
        clear_intr();
        run_frame(50, -1);
        for (int f = 0; f < 4; f++) begin
            run_frame(rand_words(), -1);
            if ($urandom_range(0, 1) == 1) clear_intr();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/h264_wr_burst_sched.md
Name: h264_wr_burst_sched

Overview:
- Sequences DDR write bursts for the H.264 I-frame encoder output stream.
- Watches the fill level of the packed 64-bit encoder FIFO and issues one burst request at a time to the AXI4 arbiter write port 0 (req/ack/done handshake).
- Places each encoded frame in a ring of DDR frame buffers.
- At end of frame, flushes the partial burst, then reports frame byte count and buffer index to the CPU via a latched interrupt.

Parameters:
- BURST_LEN, 16: full burst length in 64-bit beats (1..256).
- NUM_BUF, 4: number of frame buffers in the ring (power of 2, 2..4).
- BUF_SIZE_LOG2, 22: log2 of bytes per frame buffer (4 MiB).
- FIFO_AW, 10: encoder FIFO address width.

Ports:
- sys_clk_i  in  1  single clock, shared with the arbiter.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  encoder enable (h264_encoder_en).
- frame_ddr_addr_i  in  10  ring base; base address = {frame_ddr_addr_i, 22'h0}.
- fifo_level_i  in  FIFO_AW+1  64-bit words currently in the encoder FIFO.
- frame_end_i  in  1  1-cycle pulse: all words of the current frame are in the FIFO.
- write_req_o  out  1  burst request to the arbiter.
- write_start_addr_o  out  32  burst byte address.
- write_length_o  out  8  burst beats minus 1.
- write_ackn_i  in  1  arbiter accepted the request (pulse).
- write_done_i  in  1  burst completed on AXI (pulse).
- clr_intr_i  in  1  CPU clears the interrupt (pulse).
- frm_interrupt_o  out  1  frame-ready interrupt, latched.
- frame_index_o  out  2  buffer index of the reported frame.
- frame_bytes_o  out  32  byte count of the reported frame.
- overrun_o  out  1  sticky: a frame was reported while the interrupt was still pending.
- wrap_o  out  1  sticky: a frame exceeded its buffer size.

Behaviour:
- Reset: all outputs 0; state IDLE; buf_idx=0; ofs=0; bytes=0; eof_seen=0.
- Buffer start address = base + (buf_idx << BUF_SIZE_LOG2).
- write_start_addr_o = buffer start + ofs, where ofs is BUF_SIZE_LOG2 bits and wraps modulo the buffer size.
- Arithmetic: len_beats is 9 bits; bytes is 32 bits and adds len_beats*8; bytes does not wrap (no saturation needed).
- eof_seen sets on frame_end_i in any state except IDLE (ignored in IDLE); it clears in REPORT.
- States:
  - IDLE: when enable_i=1, go to WAIT_DATA with ofs=0 and bytes=0.
  - WAIT_DATA, evaluated in priority order:
    1. enable_i=0: go to IDLE, partial frame discarded, no report.
    2. fifo_level_i >= BURST_LEN: len_beats=BURST_LEN, go to REQ.
    3. eof_seen and fifo_level_i>0: len_beats=fifo_level_i (always < BURST_LEN), go to REQ.
    4. eof_seen and fifo_level_i=0: go to REPORT.
    5. Otherwise stay in WAIT_DATA.
  - REQ:
    - write_req_o=1; write_start_addr_o and write_length_o=len_beats-1 are registered on entry and held stable until write_ackn_i.
    - On write_ackn_i: write_req_o drops the next cycle; go to WAIT_DONE.
    - ack in the same cycle req rises is legal.
  - WAIT_DONE:
    - On write_done_i: ofs += len_beats*8 and bytes += len_beats*8; set wrap_o if ofs overflows; go to WAIT_DATA.
    - If write_done_i arrives in the cycle after ack, it is accepted.
  - REPORT (1 cycle):
    - frame_bytes_o<=bytes; frame_index_o<=buf_idx; frm_interrupt_o<=1.
    - overrun_o<=1 if frm_interrupt_o was already 1.
    - buf_idx<=(buf_idx+1) mod NUM_BUF; ofs<=0; bytes<=0; eof_seen<=0.
    - Next state: WAIT_DATA if enable_i=1, else IDLE.
- enable_i falling in REQ or WAIT_DONE: the outstanding handshake completes first; the exit happens in WAIT_DATA. write_req_o never drops before ack.
- clr_intr_i clears frm_interrupt_o the next cycle. If REPORT occurs in the same cycle, the set wins (interrupt stays 1).
- overrun_o and wrap_o clear only on reset.
- Only one burst is ever outstanding.
- Latency: frame_end_i with fifo_level_i=0 in WAIT_DATA gives frm_interrupt_o=1 two cycles later.
- frame_ddr_addr_i is sampled continuously; software changes it only while enable_i=0.

Test Plan:
- Base case: BURST_LEN=16, frame_ddr_addr_i=10'h0A0, fifo_level_i=40, frame_end_i; TB drains the FIFO on done -> bursts (addr 0x2800_0000, len 15), (0x2800_0080, 15), (0x2800_0100, 7); then frm_interrupt_o=1, frame_bytes_o=320, frame_index_o=0.
- Ring wrap: five consecutive frames -> starts at 0x2800_0000, 0x2840_0000, 0x2880_0000, 0x28C0_0000, then 0x2800_0000 again; frame_index_o sequence 0,1,2,3,0.
- Handshake hold: write_ackn_i delayed 10 cycles -> write_req_o, addr and length stable all 10 cycles; req low the cycle after ack; no second req before write_done_i.
- Interrupt timing: interrupt not cleared before the next REPORT -> overrun_o=1. clr_intr_i coincident with REPORT -> frm_interrupt_o stays 1. clr_intr_i alone -> 0 the next cycle.
- Empty frame and disable: frame_end_i with level 0 -> frame_bytes_o=0, interrupt 2 cycles later. enable_i=0 during WAIT_DONE -> burst completes, IDLE, no interrupt.
- Reset mid-operation: reset_i in REQ/WAIT_DONE -> next cycle all outputs 0; after release the first burst goes to index 0 at offset 0.
